buyruk_bellegi: RTL

Instruction-memory responder: the memory-side end of the fetch interface driven by the core's fetch stage (byte address out, instruction word in). Accepts fetch requests over a valid/ready handshake, returns the 32-bit instruction after a fixed, parameterised latency through an in-order response buffer, and flags misaligned or out-of-range fetches. A separate loader port writes program words before or during execution.

---
 rtl/buyruk_bellegi_pkg.sv | 18 +
 rtl/buyruk_bellegi_if.sv | 28 ++
 rtl/buyruk_bellegi_yanit_fifo.sv | 64 ++++++
 rtl/buyruk_bellegi.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/buyruk_bellegi_pkg.sv
// Shared definitions for the instruction-memory responder: NOP word,
// response record and the legal range of the response latency.
package kutu_paket;

    localparam logic [31:0] BUYRUK_NOP    = 32'h0000_0013;
    localparam int          GECIKME_EN_AZ  = 1;
    localparam int          GECIKME_EN_COK = 4;

    typedef struct packed {
        logic        hata;
        logic [31:0] buyruk;
    } yanit_t;

    function automatic bit gecikme_gecerli(input int gecikme);
        return (gecikme >= GECIKME_EN_AZ) && (gecikme <= GECIKME_EN_COK);
    endfunction

endpackage

// File: rtl/buyruk_bellegi_if.sv
// Fetch, response and loader signals of the instruction-memory responder.
// The master side is the core/loader, the slave side is the memory.
interface buyruk_bellegi_if #(
    parameter int ADRES_BIT = 10
);
    logic                 istek_gecerli_i;
    logic                 istek_hazir_o;
    logic [31:0]          istek_adres_i;
    logic                 yanit_gecerli_o;
    logic                 yanit_hazir_i;
    logic [31:0]          yanit_buyruk_o;
    logic                 yanit_hata_o;
    logic                 yukle_gecerli_i;
    logic [ADRES_BIT-1:0] yukle_adres_i;
    logic [31:0]          yukle_veri_i;

    modport master (
        output istek_gecerli_i, istek_adres_i, yanit_hazir_i,
               yukle_gecerli_i, yukle_adres_i, yukle_veri_i,
        input  istek_hazir_o, yanit_gecerli_o, yanit_buyruk_o, yanit_hata_o
    );

    modport slave (
        input  istek_gecerli_i, istek_adres_i, yanit_hazir_i,
               yukle_gecerli_i, yukle_adres_i, yukle_veri_i,
        output istek_hazir_o, yanit_gecerli_o, yanit_buyruk_o, yanit_hata_o
    );
endinterface

// File: rtl/buyruk_bellegi_yanit_fifo.sv
// In-order response buffer: synchronous FIFO of arbitrary depth.
// Only the pointers and the occupancy count are reset; storage is not.
module yanit_fifo #(
    parameter int DERINLIK = 3,
    parameter int GENISLIK = 33
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [GENISLIK-1:0] push_veri,
    input  logic                pop,
    output logic                full,
    output logic                empty,
    output logic [GENISLIK-1:0] bas_veri
);
    localparam int IW = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
    localparam int SW = $clog2(DERINLIK + 1);

    logic [GENISLIK-1:0] depo_r [DERINLIK];
    logic [IW-1:0]       yaz_r;
    logic [IW-1:0]       oku_r;
    logic [SW-1:0]       adet_r;

    function automatic logic [IW-1:0] sonraki(input logic [IW-1:0] p);
        if (p == IW'(DERINLIK - 1)) begin
            return '0;
        end else begin
            return p + IW'(1);
        end
    endfunction

    // Storage write at the write pointer
    always_ff @(posedge clk) begin
        if (push) begin
            depo_r[yaz_r] <= push_veri;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            yaz_r  <= '0;
            oku_r  <= '0;
            adet_r <= '0;
        end else begin
            if (push) begin
                yaz_r <= sonraki(yaz_r);
            end
            if (pop) begin
                oku_r <= sonraki(oku_r);
            end
            case ({push, pop})
                2'b10:   adet_r <= adet_r + SW'(1);
                2'b01:   adet_r <= adet_r - SW'(1);
                default: adet_r <= adet_r;
            endcase
        end
    end

    assign full     = (adet_r == SW'(DERINLIK));
    assign empty    = (adet_r == SW'(0));
    assign bas_veri = depo_r[oku_r];

endmodule

// File: rtl/buyruk_bellegi.sv
// Instruction-memory responder: accepts fetches, reads the word through a
// fixed-latency pipeline and returns responses in order through a buffer.
// The head of the response path is the buffer, or the last pipeline stage
// when the buffer is empty, so an unstalled fetch answers in GECIKME cycles.
module buyruk_bellegi
    import kutu_paket::*;
#(
    parameter int ADRES_BIT = 10,
    parameter int GECIKME   = 2
) (
    input logic              clk_i,
    input logic              rst_i,
    buyruk_bellegi_if.slave  bus
);
    localparam int DERINLIK = 1 << ADRES_BIT;
    localparam int SAYAC_W  = $clog2(GECIKME + 2);
    localparam int SON      = GECIKME - 1;

    if (!gecikme_gecerli(GECIKME)) begin : g_gecikme_denetimi
        $error("buyruk_bellegi: GECIKME out of legal range 1..4");
    end

    logic [31:0]        mem_r [DERINLIK];
    logic [GECIKME-1:0] gecerli_r;
    logic [GECIKME-1:0] hata_r;
    logic [31:0]        kelime_r [GECIKME];
    logic [SAYAC_W-1:0] sayac_r;

    logic   hazir_s;
    logic   kabul_s;
    logic   hata_s;
    logic   son_gecerli_s;
    yanit_t son_s;
    yanit_t fifo_bas_s;
    yanit_t cikis_s;
    logic   fifo_bos_s;
    logic   fifo_dolu_s;
    logic   yanit_gecerli_s;
    logic   tuketim_s;
    logic   pop_s;
    logic   push_s;

    // Credit limit keeps outstanding fetches within buffer capacity
    assign hazir_s = !bus.yukle_gecerli_i && (sayac_r < SAYAC_W'(GECIKME + 1));
    assign kabul_s = bus.istek_gecerli_i && hazir_s;
    assign hata_s  = (bus.istek_adres_i[1:0] != 2'b00) ||
                     (bus.istek_adres_i[31:ADRES_BIT+2] != '0);

    // Loader write port
    always_ff @(posedge clk_i) begin
        if (bus.yukle_gecerli_i) begin
            mem_r[bus.yukle_adres_i] <= bus.yukle_veri_i;
        end
    end

    // Stage words: synchronous memory read (NOP on error), then shift
    always_ff @(posedge clk_i) begin
        if (kabul_s && !hata_s) begin
            kelime_r[0] <= mem_r[bus.istek_adres_i[ADRES_BIT+1:2]];
        end else if (kabul_s) begin
            kelime_r[0] <= BUYRUK_NOP;
        end
        for (int k = 1; k < GECIKME; k++) begin
            kelime_r[k] <= kelime_r[k-1];
        end
    end

    // Stage valid and error flags, cleared by reset to drop in-flight work
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gecerli_r <= '0;
            hata_r    <= '0;
        end else begin
            gecerli_r[0] <= kabul_s;
            hata_r[0]    <= kabul_s && hata_s;
            for (int k = 1; k < GECIKME; k++) begin
                gecerli_r[k] <= gecerli_r[k-1];
                hata_r[k]    <= hata_r[k-1];
            end
        end
    end

    assign son_gecerli_s = gecerli_r[SON];
    assign son_s.hata    = hata_r[SON];
    assign son_s.buyruk  = kelime_r[SON];

    // Head selection: buffer first, then the last stage, else idle NOP
    always_comb begin
        cikis_s.hata   = 1'b0;
        cikis_s.buyruk = BUYRUK_NOP;
        if (!fifo_bos_s) begin
            cikis_s = fifo_bas_s;
        end else if (son_gecerli_s) begin
            cikis_s = son_s;
        end else begin
            cikis_s.hata   = 1'b0;
            cikis_s.buyruk = BUYRUK_NOP;
        end
    end

    assign yanit_gecerli_s = !fifo_bos_s || son_gecerli_s;
    assign tuketim_s       = yanit_gecerli_s && bus.yanit_hazir_i;
    assign pop_s           = tuketim_s && !fifo_bos_s;
    // The last stage bypasses the buffer only when it is the head and taken now
    assign push_s          = son_gecerli_s && !(fifo_bos_s && tuketim_s) &&
                             (!fifo_dolu_s || pop_s);

    yanit_fifo #(
        .DERINLIK (GECIKME + 1),
        .GENISLIK ($bits(yanit_t))
    ) u_yanit_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push_s),
        .push_veri (son_s),
        .pop       (pop_s),
        .full      (fifo_dolu_s),
        .empty     (fifo_bos_s),
        .bas_veri  (fifo_bas_s)
    );

    // Outstanding-request counter: accepts add, consumptions remove
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sayac_r <= '0;
        end else begin
            case ({kabul_s, tuketim_s})
                2'b10:   sayac_r <= sayac_r + SAYAC_W'(1);
                2'b01:   sayac_r <= sayac_r - SAYAC_W'(1);
                default: sayac_r <= sayac_r;
            endcase
        end
    end

    assign bus.istek_hazir_o   = hazir_s;
    assign bus.yanit_gecerli_o = yanit_gecerli_s;
    assign bus.yanit_buyruk_o  = cikis_s.buyruk;
    assign bus.yanit_hata_o    = cikis_s.hata;

endmodule
